// File: rtl/seq_player.sv
// Simon-style sequence player: fetches colour indices from a sequence memory and
// flashes one-hot LEDs for level+1 steps, with abort and level range checking.
module seq_player #(
  parameter int NUM_LEDS   = 4,
  parameter int SEL_W      = 2,
  parameter int ADDR_W     = 4,
  parameter int MAX_LEVEL  = 9,
  parameter int LED_W      = 10,
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 25_000_000,
  parameter int MEM_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] level,
  input  logic [SEL_W-1:0]  mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LED_W-1:0]  led_out
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ?
                           ((ON_CYCLES > MEM_LAT) ? ON_CYCLES : MEM_LAT) :
                           ((OFF_CYCLES > MEM_LAT) ? OFF_CYCLES : MEM_LAT);
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ON    = 3'd2,
    S_OFF   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [ADDR_W-1:0]   lvl_r, lvl_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                err_r, err_s;
  logic [LED_W-1:0]    led_r, led_s;

  // Out-of-range colour indices decode to all-dark rather than aliasing onto a real LED.
  function automatic logic [LED_W-1:0] onehot_f(input logic [SEL_W-1:0] sel);
    logic [LED_W-1:0] v;
    v = {LED_W{1'b0}};
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (sel == SEL_W'(i)) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // Next-state, counter and output decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + CNT_W'(1);
    lvl_s   = lvl_r;
    addr_s  = addr_r;
    led_s   = led_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        led_s = {LED_W{1'b0}};
        if (start) begin
          if (level > ADDR_W'(MAX_LEVEL)) begin
            err_s = 1'b1;
          end else begin
            lvl_s   = level;
            addr_s  = {ADDR_W{1'b0}};
            state_s = S_FETCH;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (cnt_r == CNT_W'(MEM_LAT - 1)) begin
          led_s   = onehot_f(mem_data);
          cnt_s   = {CNT_W{1'b0}};
          state_s = S_ON;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_ON: begin
        if (cnt_r == CNT_W'(ON_CYCLES - 1)) begin
          led_s   = {LED_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          state_s = S_OFF;
        end else begin
          state_s = S_ON;
        end
      end
      S_OFF: begin
        if (cnt_r == CNT_W'(OFF_CYCLES - 1)) begin
          cnt_s = {CNT_W{1'b0}};
          if (addr_r == lvl_r) begin
            done_s  = 1'b1;
            state_s = S_DONE;
          end else begin
            addr_s  = addr_r + ADDR_W'(1);
            state_s = S_FETCH;
          end
        end else begin
          state_s = S_OFF;
        end
      end
      S_DONE: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = S_IDLE;
      end
      default: begin
        cnt_s   = {CNT_W{1'b0}};
        led_s   = {LED_W{1'b0}};
        state_s = S_IDLE;
      end
    endcase

    // Abort wins over any in-flight transition, including the final done pulse.
    if (abort && (state_r != S_IDLE)) begin
      state_s = S_IDLE;
      cnt_s   = {CNT_W{1'b0}};
      led_s   = {LED_W{1'b0}};
      done_s  = 1'b0;
    end else begin
      state_s = state_s;
    end

    busy_s = (state_s != S_IDLE);
  end

  // State and registered-output flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      lvl_r   <= {ADDR_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      led_r   <= {LED_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      lvl_r   <= lvl_s;
      addr_r  <= addr_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      err_r   <= err_s;
      led_r   <= led_s;
    end
  end

  assign mem_addr = addr_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign led_out  = led_r;

endmodule

// File: doc/seq_player.md
Name: seq_player

Overview:
- Parametrised successor to the level-driven LED blinker in the Simon game.
- On a start pulse from the game FSM, it plays a stored colour sequence of `level+1` steps.
- For each step it fetches the colour index from the sequence memory, lights one-hot LEDs for ON_CYCLES, then blanks them for OFF_CYCLES.
- It reports completion with a single-cycle done pulse and supports abort, out-of-range level rejection, and configurable LED count, depth and memory latency.

Parameters:
- NUM_LEDS, 4: number of colour LEDs driven one-hot.
- SEL_W, 2: width of colour index from memory; must be ≥ clog2(NUM_LEDS).
- ADDR_W, 4: sequence memory address width; also the width of level.
- MAX_LEVEL, 9: highest accepted level; sequences are 1..MAX_LEVEL+1 steps.
- LED_W, 10: width of led_out; bits above NUM_LEDS-1 are always 0.
- ON_CYCLES, 25_000_000: cycles each LED is lit; must be ≥ 1.
- OFF_CYCLES, 25_000_000: blank cycles after each step; must be ≥ 1.
- MEM_LAT, 1: memory read latency in cycles; must be ≥ 1.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous active-low reset.
- start, input, 1: request playback; sampled only in IDLE.
- abort, input, 1: synchronous cancel of playback.
- level, input, ADDR_W: number of steps minus 1; latched on accepted start.
- mem_data, input, SEL_W: colour index from sequence memory, valid MEM_LAT cycles after mem_addr.
- mem_addr, output, ADDR_W: current step address (the "count" to memory).
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse after the final step's off time.
- err, output, 1: one-cycle pulse when start is rejected.
- led_out, output, LED_W: registered one-hot LED drive.

Behaviour:
- All outputs are registered. While reset is low at a clk edge, the block enters IDLE with mem_addr=0, busy=0, done=0, err=0, led_out=0 and all counters cleared. Reset overrides abort and start.
- States are IDLE, FETCH, ON, OFF, DONE.
- IDLE:
  - start=1 with level ≤ MAX_LEVEL: latch level into lvl_q, set mem_addr=0, go to FETCH, busy=1 from the next cycle.
  - start=1 with level > MAX_LEVEL: err=1 for one cycle, remain in IDLE.
  - start=0: remain in IDLE, led_out=0.
- FETCH:
  - Lasts exactly MEM_LAT cycles with mem_addr held.
  - At the exit edge, led_out is loaded with the one-hot of mem_data, then the state goes to ON.
  - If mem_data ≥ NUM_LEDS, led_out=0 for that step, but all step timing is unchanged.
- ON:
  - Lasts exactly ON_CYCLES cycles.
  - At the exit edge, led_out=0 and the state goes to OFF.
- OFF:
  - Lasts exactly OFF_CYCLES cycles.
  - At the exit edge, if mem_addr == lvl_q, go to DONE.
  - Otherwise, mem_addr increments by 1 and the state goes to FETCH.
- DONE:
  - done=1 for exactly one cycle, with busy still 1.
  - The next edge returns to IDLE with busy=0.
  - mem_addr holds its last value until the next accepted start.
- Step period is MEM_LAT+ON_CYCLES+OFF_CYCLES cycles.
  - Counting from the edge that accepts start (E0), step k's LED rises at edge E(MEM_LAT + k·period).
  - done is high in the cycle after edge E((lvl_q+1)·period).
- start while busy is ignored: no restart and no err.
- level changes after acceptance have no effect.
- abort=1 in any non-IDLE state:
  - Next edge goes to IDLE with led_out=0 and busy=0.
  - No done pulse is generated.
  - abort in IDLE has no effect.
- abort and start asserted together in IDLE: abort has no effect, start is processed normally.
- The cycle counter width is sized for max(ON_CYCLES, OFF_CYCLES, MEM_LAT) and is cleared on every state entry. No wrap-around is ever reached.
- mem_addr never exceeds MAX_LEVEL, so it cannot wrap.

Test Plan:
1. Nominal play, with ON_CYCLES=4, OFF_CYCLES=2, MEM_LAT=1, memory {2,0,3}: reset, then a start pulse with level=2.
   - led_out=0100 during E1–E5, 0001 during E8–E12, 1000 during E15–E19.
   - done is high in the cycle after edge E21, only in that cycle; busy falls at E22.
   - mem_addr sequence is 0, 1, 2.
2. Single step, with level=0 and memory[0]=1: led_out=0010 for 4 cycles, then done after 7 cycles total; mem_addr stays 0.
3. Rejection: start with level=12 (MAX_LEVEL=9) → err pulses for 1 cycle; busy, led_out and done stay 0.
4. Abort: assert abort mid-ON of step 1 → next edge led_out=0 and busy=0; done never asserts. A subsequent start with level=1 then plays from mem_addr=0.
5. Reset mid-operation: drive reset low during OFF of step 2 → next edge all outputs are 0. start while reset is low is ignored; after reset releases, a start replays from step 0.
6. Corner cases:
   - start held high through playback → exactly one playback.
   - A new start on the cycle after done is accepted.
   - With NUM_LEDS=3, mem_data=3 → led_out=0 for that step, with timing unchanged.
